// File: rtl/hazard_pkg.sv
// Shared types for the RV32I hazard/pipeline-control slice.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package hazard_pkg;

    // Shadow records carry register addresses at this fixed width; narrower
    // architectural addresses are zero-extended on entry.
    localparam int REC_AW = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_ME = 2'b01,
        FWD_WB = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic              v;
        logic [REC_AW-1:0] rd;
        logic              wr;
        logic              load;
        logic [REC_AW-1:0] rs1;
        logic [REC_AW-1:0] rs2;
    } stage_rec_t;

    // A valid, writing, non-x0 instruction whose rd equals the source.
    function automatic logic wr_match(input stage_rec_t w, input logic [REC_AW-1:0] s);
        return w.v & w.wr & (w.rd != '0) & (w.rd == s);
    endfunction

    // ME wins over WB (younger value). A load in ME is skipped: the
    // load-use stall guarantees its consumer only meets it in WB.
    function automatic fwd_sel_t pick_fwd(input stage_rec_t me, input stage_rec_t wb,
                                          input logic [REC_AW-1:0] src);
        if (wr_match(me, src) && !me.load) begin
            return FWD_ME;
        end
        if (wr_match(wb, src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Latency: count visible one cycle after the increment request.
// Backpressure: none; sticks at all-ones once reached.
// Ports: clk_i, rst_ni (async active-low), inc_i (count this edge), q_o (value).
module sat_counter
    import hazard_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         inc_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline control for the 5-stage RV32I core: stalls, flushes, EX forwarding selects, perf counters.
// Latency: all outputs combinational from shadow state and inputs; shadow state advances once per unfrozen edge.
// Backpressure: dm_busy_i freezes every stage; load-use (or any RAW when forwarding is off) stalls IF/DE for a bubble.
// Ports: clk_i, rst_ni; de_* describe the instruction in DE; branch_taken_i from EX; dm_busy_i from data memory;
//        *_en_o / *_flush_o drive the four pipeline registers; fwd_*_sel_o pick EX operands; *_cnt_o are counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [REG_AW-1:0] de_rs1_i,
    input  logic [REG_AW-1:0] de_rs2_i,
    input  logic              de_use_rs1_i,
    input  logic              de_use_rs2_i,
    input  logic [REG_AW-1:0] de_rd_i,
    input  logic              de_ru_write_i,
    input  logic              de_is_load_i,
    input  logic              branch_taken_i,
    input  logic              dm_busy_i,
    output logic              pc_en_o,
    output logic              if_de_en_o,
    output logic              if_de_flush_o,
    output logic              de_ex_en_o,
    output logic              de_ex_flush_o,
    output logic              ex_me_en_o,
    output logic              me_wb_en_o,
    output logic [1:0]        fwd_a_sel_o,
    output logic [1:0]        fwd_b_sel_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    logic       de_v_q, de_v_d;
    stage_rec_t ex_q, ex_d, me_q, me_d, wb_q, wb_d;

    logic [REC_AW-1:0] rs1_x, rs2_x;
    logic              ex_hit, me_hit, wb_hit;
    logic              load_use, raw_any, hazard;
    fwd_sel_t          fwd_a, fwd_b;

    assign rs1_x = REC_AW'(de_rs1_i);
    assign rs2_x = REC_AW'(de_rs2_i);

    // Does an older stage write a source the DE instruction actually reads?
    assign ex_hit = (de_use_rs1_i & wr_match(ex_q, rs1_x)) | (de_use_rs2_i & wr_match(ex_q, rs2_x));
    assign me_hit = (de_use_rs1_i & wr_match(me_q, rs1_x)) | (de_use_rs2_i & wr_match(me_q, rs2_x));
    assign wb_hit = (de_use_rs1_i & wr_match(wb_q, rs1_x)) | (de_use_rs2_i & wr_match(wb_q, rs2_x));

    // With forwarding only a load directly ahead must wait; without it any
    // in-flight producer blocks DE until it has left WB.
    assign load_use = de_v_q & ex_q.load & ex_hit;
    assign raw_any  = de_v_q & (ex_hit | me_hit | wb_hit);
    assign hazard   = (FWD_EN != 0) ? load_use : raw_any;

    assign fwd_a       = (FWD_EN != 0) ? pick_fwd(me_q, wb_q, ex_q.rs1) : FWD_RF;
    assign fwd_b       = (FWD_EN != 0) ? pick_fwd(me_q, wb_q, ex_q.rs2) : FWD_RF;
    assign fwd_a_sel_o = fwd_a;
    assign fwd_b_sel_o = fwd_b;

    // Pipeline-register controls; freeze > branch > stall > normal.
    always_comb begin
        pc_en_o       = 1'b1;
        if_de_en_o    = 1'b1;
        if_de_flush_o = 1'b0;
        de_ex_en_o    = 1'b1;
        de_ex_flush_o = 1'b0;
        ex_me_en_o    = 1'b1;
        me_wb_en_o    = 1'b1;
        if (dm_busy_i) begin
            pc_en_o    = 1'b0;
            if_de_en_o = 1'b0;
            de_ex_en_o = 1'b0;
            ex_me_en_o = 1'b0;
            me_wb_en_o = 1'b0;
        end else if (branch_taken_i) begin
            if_de_flush_o = 1'b1;
            de_ex_flush_o = 1'b1;
        end else if (hazard) begin
            pc_en_o       = 1'b0;
            if_de_en_o    = 1'b0;
            de_ex_flush_o = 1'b1;
        end
    end

    // Shadow scoreboard next state. Squashed records are cleared entirely so
    // stale rs fields cannot produce forwarding selects.
    always_comb begin
        de_v_d = de_v_q;
        ex_d   = ex_q;
        me_d   = me_q;
        wb_d   = wb_q;
        if (!dm_busy_i) begin
            me_d = ex_q;
            wb_d = me_q;
            ex_d = '0;
            if (branch_taken_i) begin
                de_v_d = 1'b0;
            end else if (!hazard) begin
                de_v_d    = 1'b1;
                ex_d.v    = de_v_q;
                ex_d.rd   = REC_AW'(de_rd_i);
                ex_d.wr   = de_ru_write_i;
                ex_d.load = de_is_load_i;
                ex_d.rs1  = rs1_x;
                ex_d.rs2  = rs2_x;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            de_v_q <= 1'b0;
            ex_q   <= '0;
            me_q   <= '0;
            wb_q   <= '0;
        end else begin
            de_v_q <= de_v_d;
            ex_q   <= ex_d;
            me_q   <= me_d;
            wb_q   <= wb_d;
        end
    end

    // A freeze is counted as a stall cycle; a branch masks a coincident stall.
    logic stall_inc, flush_inc, retire_inc;
    assign stall_inc  = dm_busy_i | (~branch_taken_i & hazard);
    assign flush_inc  = ~dm_busy_i & branch_taken_i;
    assign retire_inc = ~dm_busy_i & wb_q.v;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (stall_inc),
        .q_o    (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (flush_inc),
        .q_o    (flush_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_retire_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (retire_inc),
        .q_o    (retire_cnt_o)
    );

    // WB only ever reports valid/write/rd; its remaining fields retire here.
    logic unused_wb_bits;
    assign unused_wb_bits = ^{wb_q.load, wb_q.rs1, wb_q.rs2};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic against an instruction-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_hazard_ctrl;

    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] de_rs1, de_rs2, de_rd;
    logic de_use_rs1, de_use_rs2, de_ru_write, de_is_load, branch_taken, dm_busy;

    // index 0: FWD_EN=0, index 1: FWD_EN=1, index 2: FWD_EN=1 with 3-bit counters
    logic        pc_en [3], if_de_en [3], if_de_flush [3], de_ex_en [3];
    logic        de_ex_flush [3], ex_me_en [3], me_wb_en [3];
    logic [1:0]  fwd_a [3], fwd_b [3];
    logic [31:0] st_c [2], fl_c [2], rt_c [2];
    logic [2:0]  st_s, fl_s, rt_s;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hazard_ctrl #(.REG_AW(AW), .FWD_EN(g), .CNT_W(32)) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .de_rs1_i(de_rs1), .de_rs2_i(de_rs2),
            .de_use_rs1_i(de_use_rs1), .de_use_rs2_i(de_use_rs2),
            .de_rd_i(de_rd), .de_ru_write_i(de_ru_write), .de_is_load_i(de_is_load),
            .branch_taken_i(branch_taken), .dm_busy_i(dm_busy),
            .pc_en_o(pc_en[g]), .if_de_en_o(if_de_en[g]), .if_de_flush_o(if_de_flush[g]),
            .de_ex_en_o(de_ex_en[g]), .de_ex_flush_o(de_ex_flush[g]),
            .ex_me_en_o(ex_me_en[g]), .me_wb_en_o(me_wb_en[g]),
            .fwd_a_sel_o(fwd_a[g]), .fwd_b_sel_o(fwd_b[g]),
            .stall_cnt_o(st_c[g]), .flush_cnt_o(fl_c[g]), .retire_cnt_o(rt_c[g])
        );
    end

    hazard_ctrl #(.REG_AW(AW), .FWD_EN(1), .CNT_W(3)) u_small (
        .clk_i(clk), .rst_ni(rst_n),
        .de_rs1_i(de_rs1), .de_rs2_i(de_rs2),
        .de_use_rs1_i(de_use_rs1), .de_use_rs2_i(de_use_rs2),
        .de_rd_i(de_rd), .de_ru_write_i(de_ru_write), .de_is_load_i(de_is_load),
        .branch_taken_i(branch_taken), .dm_busy_i(dm_busy),
        .pc_en_o(pc_en[2]), .if_de_en_o(if_de_en[2]), .if_de_flush_o(if_de_flush[2]),
        .de_ex_en_o(de_ex_en[2]), .de_ex_flush_o(de_ex_flush[2]),
        .ex_me_en_o(ex_me_en[2]), .me_wb_en_o(me_wb_en[2]),
        .fwd_a_sel_o(fwd_a[2]), .fwd_b_sel_o(fwd_b[2]),
        .stall_cnt_o(st_s), .flush_cnt_o(fl_s), .retire_cnt_o(rt_s)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- instruction-level reference model ----------------
    typedef struct { bit v; bit wr; bit ld; int rd; int rs1; int rs2; } ins_t;

    ins_t             pipe [2][3];   // [mode][0=EX,1=ME,2=WB]
    bit               de_v [2];
    longint unsigned  m_st [2], m_fl [2], m_rt [2];

    function automatic bit writes(ins_t w, int s);
        return w.v && w.wr && (w.rd != 0) && (w.rd == s);
    endfunction

    // mode 1: only a load immediately ahead blocks; mode 0: any in-flight producer blocks
    function automatic bit m_hazard(int m);
        int src [2];
        bit used [2];
        bit h = 0;
        if (!de_v[m]) return 0;
        src[0] = int'(de_rs1); src[1] = int'(de_rs2);
        used[0] = de_use_rs1;  used[1] = de_use_rs2;
        for (int i = 0; i < 2; i++) begin
            if (used[i]) begin
                for (int k = 0; k < 3; k++) begin
                    if (writes(pipe[m][k], src[i]) && (m == 0 || (k == 0 && pipe[m][k].ld))) h = 1;
                end
            end
        end
        return h;
    endfunction

    function automatic int m_fwd(int src);
        if (writes(pipe[1][1], src) && !pipe[1][1].ld) return 1;
        if (writes(pipe[1][2], src)) return 2;
        return 0;
    endfunction

    // {pc_en, if_de_en, if_de_flush, de_ex_en, de_ex_flush, ex_me_en, me_wb_en}
    function automatic logic [6:0] m_ctl(int m);
        if (dm_busy) return 7'b0000000;
        if (branch_taken) return 7'b1111111;
        if (m_hazard(m)) return 7'b0001111;
        return 7'b1101011;
    endfunction

    function automatic logic [6:0] obs_ctl(int i);
        return {pc_en[i], if_de_en[i], if_de_flush[i], de_ex_en[i], de_ex_flush[i], ex_me_en[i], me_wb_en[i]};
    endfunction

    function automatic longint unsigned sat7(longint unsigned x);
        return (x > 7) ? 7 : x;
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            de_v[m] = 0;
            for (int k = 0; k < 3; k++) pipe[m][k] = '{default: 0};
            m_st[m] = 0; m_fl[m] = 0; m_rt[m] = 0;
        end
    endtask

    task automatic m_step(int m);
        ins_t nx;
        bit   h;
        if (dm_busy) begin
            m_st[m]++;
            return;
        end
        h  = m_hazard(m);
        nx = '{default: 0};
        if (pipe[m][2].v) m_rt[m]++;
        if (branch_taken) m_fl[m]++;
        else if (h) m_st[m]++;
        if (!branch_taken && !h) begin
            nx.v = de_v[m]; nx.wr = de_ru_write; nx.ld = de_is_load;
            nx.rd = int'(de_rd); nx.rs1 = int'(de_rs1); nx.rs2 = int'(de_rs2);
        end
        pipe[m][2] = pipe[m][1];
        pipe[m][1] = pipe[m][0];
        pipe[m][0] = nx;
        if (branch_taken) de_v[m] = 0;
        else if (!h) de_v[m] = 1;
    endtask

    task automatic check_all();
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("ctl[%0d]", m), obs_ctl(m), m_ctl(m));
            chk($sformatf("fwd_a[%0d]", m), fwd_a[m], (m == 1) ? m_fwd(pipe[1][0].rs1) : 0);
            chk($sformatf("fwd_b[%0d]", m), fwd_b[m], (m == 1) ? m_fwd(pipe[1][0].rs2) : 0);
            chk($sformatf("stall[%0d]", m), st_c[m], m_st[m]);
            chk($sformatf("flush[%0d]", m), fl_c[m], m_fl[m]);
            chk($sformatf("retire[%0d]", m), rt_c[m], m_rt[m]);
        end
        chk("ctl_small", obs_ctl(2), m_ctl(1));
        chk("fwd_a_small", fwd_a[2], m_fwd(pipe[1][0].rs1));
        chk("stall_small", st_s, sat7(m_st[1]));
        chk("flush_small", fl_s, sat7(m_fl[1]));
        chk("retire_small", rt_s, sat7(m_rt[1]));
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_de(int rs1, int rs2, bit u1, bit u2, int rd, bit wr, bit ld);
        de_rs1 = AW'(rs1); de_rs2 = AW'(rs2);
        de_use_rs1 = u1; de_use_rs2 = u2;
        de_rd = AW'(rd); de_ru_write = wr; de_is_load = ld;
        branch_taken = 0; dm_busy = 0;
    endtask

    task automatic nop();
        set_de(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic tick();
        m_step(0);
        m_step(1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic nops(int n);
        for (int i = 0; i < n; i++) begin
            nop(); settle(); tick();
        end
    endtask

    int raw_stalls;

    initial begin
        nop();
        m_reset();
        repeat (2) @(negedge clk);
        settle();
        rst_n = 1'b1;
        settle();
        chk("rst_ctl", obs_ctl(1), 7'b1101011);
        chk("rst_fwd", fwd_a[1], 0);
        chk("rst_retire", rt_c[1], 0);

        // ten independent ALU ops
        for (int i = 0; i < 10; i++) begin
            set_de(0, 0, 0, 0, i + 1, 1, 0); settle(); tick();
        end
        nop(); settle();
        chk("alu_retire", rt_c[1], 6);
        nops(3);

        // lw x5 ; add x6,x5,x1 -> one bubble, then WB forwarding
        set_de(0, 0, 0, 0, 5, 1, 1); settle(); tick();
        set_de(5, 1, 1, 1, 6, 1, 0); settle();
        chk("lu_pc_en", pc_en[1], 0);
        chk("lu_bubble", de_ex_flush[1], 1);
        tick();
        settle();
        chk("lu_resume", pc_en[1], 1);
        tick();
        nop(); settle();
        chk("lu_fwd_a", fwd_a[1], 2);
        chk("lu_stall_cnt", st_c[1], 1);
        nops(3);

        // add x5 ; sub x7,x5,x5 -> ME forwarding on both operands
        set_de(0, 0, 0, 0, 5, 1, 0); settle(); tick();
        set_de(5, 5, 1, 1, 7, 1, 0); settle();
        chk("alu_nostall", pc_en[1], 1);
        tick();
        nop(); settle();
        chk("me_fwd_a", fwd_a[1], 1);
        chk("me_fwd_b", fwd_b[1], 1);
        nops(3);

        // same with x0 destination -> never forwarded
        set_de(0, 0, 0, 0, 0, 1, 0); settle(); tick();
        set_de(0, 0, 1, 1, 7, 1, 0); settle(); tick();
        nop(); settle();
        chk("x0_fwd_a", fwd_a[1], 0);
        chk("x0_fwd_b", fwd_b[1], 0);
        nops(3);

        // branch coincident with a load-use hazard
        set_de(0, 0, 0, 0, 5, 1, 1); settle(); tick();
        set_de(5, 1, 1, 1, 6, 1, 0); branch_taken = 1; settle();
        chk("br_if_flush", if_de_flush[1], 1);
        chk("br_de_flush", de_ex_flush[1], 1);
        chk("br_pc_en", pc_en[1], 1);
        tick();
        nop(); settle();
        chk("br_flush_cnt", fl_c[1], 1);
        chk("br_stall_cnt", st_c[1], 1);
        nops(3);

        // freeze for 3 cycles with a load in ME
        set_de(0, 0, 0, 0, 9, 1, 1); settle(); tick();
        nop(); settle(); tick();
        for (int i = 0; i < 3; i++) begin
            nop(); dm_busy = 1; settle();
            chk("frz_ctl", obs_ctl(1), 7'b0000000);
            tick();
        end
        nop(); settle();
        chk("frz_stall_cnt", st_c[1], 4);
        nops(4);

        // no forwarding: add x5 ; or x8,x5,x0 -> three stall cycles
        set_de(0, 0, 0, 0, 5, 1, 0); settle(); tick();
        set_de(5, 0, 1, 1, 8, 1, 0);
        raw_stalls = 0;
        for (int i = 0; i < 8; i++) begin
            settle();
            if (pc_en[0]) break;
            raw_stalls++;
            chk("raw_fwd_a", fwd_a[0], 0);
            tick();
        end
        chk("raw_penalty", raw_stalls, 3);
        tick();
        nops(4);

        // reset pulsed in the middle of a RAW stall
        set_de(0, 0, 0, 0, 5, 1, 0); settle(); tick();
        set_de(5, 0, 1, 1, 8, 1, 0); settle(); tick();
        settle();
        chk("pre_rst_stall", pc_en[0], 0);
        rst_n = 1'b0;
        m_reset();
        settle();
        chk("mid_rst_stall", st_c[0], 0);
        chk("mid_rst_retire", rt_c[0], 0);
        chk("mid_rst_ctl", obs_ctl(0), 7'b1101011);
        #1 rst_n = 1'b1;
        tick();

        // randomized traffic over a small register window to provoke hazards
        for (int c = 0; c < 1500; c++) begin
            set_de(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 99) < 30));
            branch_taken = ($urandom_range(0, 99) < 8);
            dm_busy      = ($urandom_range(0, 99) < 10);
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
